// File: rtl/oflow_mem_buffer_scheduler.sv
// Per-frame slot sequencer and single-port arbiter for the tracking MEM buffer.
// Define OFLOW_SCHED_RR_EN for round-robin arbitration (default: write priority).
module oflow_mem_buffer_scheduler #(
  parameter int MAX_HISTORY  = 5,
  parameter int SLOT_W       = 3,
  parameter int OFFSET_WIDTH = 6,
  parameter int BBOX_W       = 7
) (
  input  logic                           clk,
  input  logic                           reset_N,
  input  logic                           frame_start,
  input  logic [7:0]                     frame_num,
  input  logic [2:0]                     num_of_history_frames,
  input  logic [BBOX_W-1:0]              num_of_bbox_in_frame,
  input  logic                           wr_req,
  input  logic                           rd_req,
  output logic                           wr_gnt,
  output logic                           rd_gnt,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [SLOT_W+OFFSET_WIDTH-1:0] mem_addr,
  output logic [7:0]                     frame_to_read,
  output logic                           busy,
  output logic                           frame_done
);

  localparam logic [SLOT_W-1:0] LP_MAXH  = SLOT_W'(MAX_HISTORY);
  localparam logic [SLOT_W-1:0] LP_SAT   = SLOT_W'(MAX_HISTORY - 1);
  localparam logic [BBOX_W-1:0] LP_DEPTH = BBOX_W'(2 ** OFFSET_WIDTH);
  localparam logic [SLOT_W-1:0] LP_S1    = SLOT_W'(1);
  localparam logic [BBOX_W-1:0] LP_B1    = BBOX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t                          r_state;
  logic [7:0]                      r_frame_num;
  logic [SLOT_W-1:0]               r_n;
  logic [BBOX_W-1:0]               r_nbbox;
  logic [SLOT_W-1:0]               r_wr_slot;
  logic [SLOT_W-1:0]               r_cur_slot;
  logic [SLOT_W-1:0]               r_frames_seen;
  logic [SLOT_W-1:0]               r_hist_cnt;
  logic [SLOT_W-1:0]               r_k;
  logic [BBOX_W-1:0]               r_wr_cnt;
  logic [BBOX_W-1:0]               r_rd_off;
  logic [BBOX_W-1:0]               r_end_ptr [MAX_HISTORY];
  logic [7:0]                      r_ftr;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_mem_en;
  logic                            r_mem_we;
  logic [SLOT_W+OFFSET_WIDTH-1:0]  r_mem_addr;
`ifdef OFLOW_SCHED_RR_EN
  logic                            r_last_wr;
`endif

  logic [SLOT_W-1:0] w_n_in;
  logic [SLOT_W-1:0] w_n_clamp;
  logic [BBOX_W-1:0] w_nb_clamp;
  logic [SLOT_W-1:0] w_nm1;
  logic [SLOT_W-1:0] w_cur_inc;
  logic [SLOT_W-1:0] w_rd_slot;
  logic [BBOX_W-1:0] w_rd_end;
  logic              w_run;
  logic              w_wr_done;
  logic              w_rd_done;
  logic              w_skip;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_wr_win;
  logic              w_rd_last;

  assign w_n_in     = SLOT_W'(num_of_history_frames);
  assign w_n_clamp  = (w_n_in == '0) ? LP_S1 :
                      (w_n_in > LP_MAXH) ? LP_MAXH : w_n_in;
  assign w_nb_clamp = (num_of_bbox_in_frame > LP_DEPTH) ?
                      LP_DEPTH : num_of_bbox_in_frame;
  assign w_nm1      = r_n - LP_S1;
  assign w_cur_inc  = (r_cur_slot + LP_S1 == r_n) ? '0 : r_cur_slot + LP_S1;

  // history slots sit behind the current slot, modulo N
  assign w_rd_slot  = (r_cur_slot >= r_k) ? r_cur_slot - r_k :
                      r_cur_slot + r_n - r_k;
  assign w_rd_end   = r_end_ptr[w_rd_slot];

  assign w_run      = (r_state == S_RUN);
  assign w_wr_done  = (r_wr_cnt == r_nbbox);
  assign w_rd_done  = (r_k > r_hist_cnt);
  assign w_skip     = w_run && !w_rd_done && (w_rd_end == '0);
  assign w_wr_ok    = w_run && !w_wr_done && wr_req;
  assign w_rd_ok    = w_run && !w_rd_done && (w_rd_end != '0) && rd_req;
  assign w_rd_last  = (r_rd_off + LP_B1) == w_rd_end;

`ifdef OFLOW_SCHED_RR_EN
  assign w_wr_win   = w_wr_ok && (!w_rd_ok || !r_last_wr);
`else
  assign w_wr_win   = w_wr_ok;
`endif

  assign wr_gnt        = w_wr_win;
  assign rd_gnt        = w_rd_ok && !w_wr_win;
  assign mem_en        = r_mem_en;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign frame_to_read = r_ftr;
  assign busy          = r_busy;
  assign frame_done    = r_done;

  always_ff @(posedge clk) begin
    if (reset_N) begin
      r_state       <= S_IDLE;
      r_frame_num   <= '0;
      r_n           <= '0;
      r_nbbox       <= '0;
      r_wr_slot     <= '0;
      r_cur_slot    <= '0;
      r_frames_seen <= '0;
      r_hist_cnt    <= '0;
      r_k           <= '0;
      r_wr_cnt      <= '0;
      r_rd_off      <= '0;
      r_ftr         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
`ifdef OFLOW_SCHED_RR_EN
      r_last_wr     <= 1'b0;
`endif
      for (int i = 0; i < MAX_HISTORY; i++) r_end_ptr[i] <= '0;
    end else begin
      r_done   <= 1'b0;
      r_mem_en <= wr_gnt || rd_gnt;
      r_mem_we <= wr_gnt;
      if (wr_gnt)
        r_mem_addr <= {r_cur_slot, r_wr_cnt[OFFSET_WIDTH-1:0]};
      else if (rd_gnt)
        r_mem_addr <= {w_rd_slot, r_rd_off[OFFSET_WIDTH-1:0]};
      unique case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_frame_num <= frame_num;
            r_n         <= w_n_clamp;
            r_nbbox     <= w_nb_clamp;
            r_busy      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cur_slot <= r_wr_slot % r_n;
          r_hist_cnt <= (r_frames_seen < w_nm1) ? r_frames_seen : w_nm1;
          r_k        <= LP_S1;
          r_wr_cnt   <= '0;
          r_rd_off   <= '0;
          r_ftr      <= r_frame_num - 8'd1;
`ifdef OFLOW_SCHED_RR_EN
          r_last_wr  <= 1'b0;
`endif
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (wr_gnt) r_wr_cnt <= r_wr_cnt + LP_B1;
          if (rd_gnt) begin
            if (w_rd_last) begin
              r_rd_off <= '0;
              r_k      <= r_k + LP_S1;
              r_ftr    <= r_ftr - 8'd1;
            end else begin
              r_rd_off <= r_rd_off + LP_B1;
            end
          end else if (w_skip) begin
            r_k   <= r_k + LP_S1;
            r_ftr <= r_ftr - 8'd1;
          end
`ifdef OFLOW_SCHED_RR_EN
          if (wr_gnt) r_last_wr <= 1'b1;
          else if (rd_gnt) r_last_wr <= 1'b0;
`endif
          if (w_wr_done && w_rd_done) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_end_ptr[r_cur_slot] <= r_nbbox;
          r_wr_slot             <= w_cur_inc;
          if (r_frames_seen != LP_SAT)
            r_frames_seen <= r_frames_seen + LP_S1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_mem_buffer_scheduler.sv
// Randomized bench for oflow_mem_buffer_scheduler against a queue-based model
// of per-frame write/read address lists and arbitration.
module tb_oflow_mem_buffer_scheduler;

  localparam int MH = 5;
  localparam int SW = 3;
  localparam int OW = 6;
  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          reset_N;
  logic          frame_start;
  logic [7:0]    frame_num;
  logic [2:0]    num_of_history_frames;
  logic [BW-1:0] num_of_bbox_in_frame;
  logic          wr_req;
  logic          rd_req;
  logic          wr_gnt;
  logic          rd_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [SW+OW-1:0] mem_addr;
  logic [7:0]    frame_to_read;
  logic          busy;
  logic          frame_done;

  oflow_mem_buffer_scheduler #(
    .MAX_HISTORY(MH), .SLOT_W(SW), .OFFSET_WIDTH(OW), .BBOX_W(BW)
  ) dut (
    .clk(clk), .reset_N(reset_N), .frame_start(frame_start),
    .frame_num(frame_num), .num_of_history_frames(num_of_history_frames),
    .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .wr_req(wr_req), .rd_req(rd_req), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .frame_to_read(frame_to_read), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int m_ep [MH];
  int m_wr_slot;
  int m_seen;

  typedef struct {
    bit skip;
    int addr;
    int ftr;
  } rd_e_t;

  task automatic model_reset();
    for (int i = 0; i < MH; i++) m_ep[i] = 0;
    m_wr_slot = 0;
    m_seen = 0;
  endtask

  task automatic run_frame(input int fn, input int nh, input int nbi,
                           input int wp, input int rp,
                           input bit rd_first, input bit noise);
    int wq[$];
    rd_e_t rq[$];
    rd_e_t e;
    int n, nb, cur, hist, s;
    bit lastw, last, w_ok, r_ok, ewg, erg;
    bit pe_en, pe_we;
    logic [SW+OW-1:0] pe_addr;
    n = (nh == 0) ? 1 : (nh > MH) ? MH : nh;
    nb = (nbi > 64) ? 64 : nbi;
    cur = m_wr_slot % n;
    hist = (m_seen < n - 1) ? m_seen : n - 1;
    for (int i = 0; i < nb; i++) wq.push_back(cur * 64 + i);
    for (int k = 1; k <= hist; k++) begin
      s = (cur - k + n) % n;
      e.ftr = (fn - k) & 255;
      if (m_ep[s] == 0) begin
        e.skip = 1'b1; e.addr = 0; rq.push_back(e);
      end else begin
        for (int o = 0; o < m_ep[s]; o++) begin
          e.skip = 1'b0; e.addr = s * 64 + o; rq.push_back(e);
        end
      end
    end
    lastw = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    frame_num = 8'(fn);
    num_of_history_frames = 3'(nh);
    num_of_bbox_in_frame = BW'(nbi);
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    n_cmp++;
    if ({busy, frame_done, wr_gnt, rd_gnt, mem_en} !== 5'b10000) begin
      n_fail++;
      $display("FAIL setup fn=%0d: busy/done/wg/rg/en=%b need 10000",
               fn, {busy, frame_done, wr_gnt, rd_gnt, mem_en});
    end
    pe_en = 1'b0; pe_we = 1'b0; pe_addr = '0;
    last = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      last = (wq.size() == 0) && (rq.size() == 0);
      if (rd_first) wr_req = (rq.size() == 0) && ($urandom_range(0, 99) < wp);
      else wr_req = ($urandom_range(0, 99) < wp);
      rd_req = ($urandom_range(0, 99) < rp);
      if (noise) begin
        frame_start = ($urandom_range(0, 5) == 0);
        frame_num = 8'($urandom);
        num_of_history_frames = 3'($urandom);
        num_of_bbox_in_frame = BW'($urandom);
      end
      #1;
      w_ok = (wq.size() > 0) && wr_req;
      r_ok = (rq.size() > 0) && !rq[0].skip && rd_req;
`ifdef OFLOW_SCHED_RR_EN
      ewg = w_ok && (!r_ok || !lastw);
`else
      ewg = w_ok;
`endif
      erg = r_ok && !ewg;
      n_cmp++;
      if ({wr_gnt, rd_gnt, busy, frame_done} !== {ewg, erg, 2'b10}) begin
        n_fail++;
        $display("FAIL run fn=%0d cyc=%0d: wg/rg/busy/done=%b need %b",
                 fn, cyc, {wr_gnt, rd_gnt, busy, frame_done},
                 {ewg, erg, 2'b10});
      end
      if (rq.size() > 0) begin
        n_cmp++;
        if (frame_to_read !== 8'(rq[0].ftr)) begin
          n_fail++;
          $display("FAIL frame_to_read fn=%0d: got %0d need %0d",
                   fn, frame_to_read, rq[0].ftr);
        end
      end
      n_cmp++;
      if (mem_en !== pe_en || (pe_en &&
          (mem_we !== pe_we || mem_addr !== pe_addr))) begin
        n_fail++;
        $display("FAIL mem fn=%0d cyc=%0d: en/we/addr=%b/%b/%0h need %b/%b/%0h",
                 fn, cyc, mem_en, mem_we, mem_addr, pe_en, pe_we, pe_addr);
      end
      pe_en = ewg || erg;
      pe_we = ewg;
      if (ewg) begin
        pe_addr = (SW+OW)'(wq.pop_front());
        lastw = 1'b1;
      end else if (erg) begin
        e = rq.pop_front();
        pe_addr = (SW+OW)'(e.addr);
        lastw = 1'b0;
      end
      if (!ewg && !erg && rq.size() > 0 && rq[0].skip) void'(rq.pop_front());
      else if (ewg && rq.size() > 0 && rq[0].skip) void'(rq.pop_front());
      if (last) break;
    end
    if (!last) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout fn=%0d: frame never completed", fn);
    end
    @(negedge clk);
    frame_start = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    n_cmp++;
    if ({frame_done, busy, wr_gnt, rd_gnt, mem_en} !== 5'b10000) begin
      n_fail++;
      $display("FAIL done fn=%0d: done/busy/wg/rg/en=%b need 10000",
               fn, {frame_done, busy, wr_gnt, rd_gnt, mem_en});
    end
    m_ep[cur] = nb;
    m_wr_slot = (cur + 1) % n;
    if (m_seen < MH - 1) m_seen++;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({frame_done, busy, wr_gnt, rd_gnt, mem_en} !== 5'b00000) begin
      n_fail++;
      $display("FAIL idle fn=%0d: done/busy/wg/rg/en=%b need 00000",
               fn, {frame_done, busy, wr_gnt, rd_gnt, mem_en});
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_N = 1'b1;
    frame_start = 1'b1;
    frame_num = 8'd0;
    num_of_history_frames = 3'd3;
    num_of_bbox_in_frame = '0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({wr_gnt, rd_gnt, mem_en, mem_we, busy, frame_done} !== 6'b0 ||
        mem_addr !== '0 || frame_to_read !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: flags=%b addr=%0h ftr=%0d need all 0",
               {wr_gnt, rd_gnt, mem_en, mem_we, busy, frame_done},
               mem_addr, frame_to_read);
    end
    reset_N = 1'b0;
    frame_start = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    model_reset();
  endtask

  task automatic test_write_only();
    run_frame(0, 3, 4, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_then_write();
    run_frame(1, 3, 2, 100, 100, 1'b1, 1'b0);
  endtask

  task automatic test_contention();
    run_frame(2, 3, 3, 100, 100, 1'b0, 1'b0);
  endtask

  task automatic test_skip_empty_slot();
    run_frame(3, 3, 0, 100, 100, 1'b0, 1'b0);
    run_frame(4, 3, 5, 100, 100, 1'b1, 1'b0);
  endtask

  task automatic test_clamp();
    run_frame(5, 7, 100, 100, 60, 1'b0, 1'b0);
    run_frame(6, 0, 70, 70, 100, 1'b0, 1'b0);
    run_frame(7, 5, 64, 50, 50, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_frame($urandom_range(0, 255), $urandom_range(0, 7),
                $urandom_range(0, 127), $urandom_range(20, 100),
                $urandom_range(20, 100), 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    frame_start = 1'b1;
    frame_num = 8'd20;
    num_of_history_frames = 3'd4;
    num_of_bbox_in_frame = BW'(30);
    wr_req = 1'b1;
    rd_req = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (5) @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    reset_N = 1'b0;
    #1;
    n_cmp++;
    if ({wr_gnt, rd_gnt, mem_en, mem_we, busy, frame_done} !== 6'b0 ||
        mem_addr !== '0 || frame_to_read !== 8'd0) begin
      n_fail++;
      $display("FAIL mid-run reset: flags=%b addr=%0h ftr=%0d need all 0",
               {wr_gnt, rd_gnt, mem_en, mem_we, busy, frame_done},
               mem_addr, frame_to_read);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    model_reset();
    run_frame(21, 4, 3, 100, 100, 1'b0, 1'b0);
    run_frame(22, 4, 2, 100, 100, 1'b0, 1'b0);
  endtask

  task automatic test_empty_frames();
    for (int i = 0; i < 300; i++)
      run_frame(i & 255, 5, 0, 50, 50, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_read_then_write();
    test_contention();
    test_skip_empty_slot();
    test_clamp();
    test_random();
    test_reset_mid_run();
    test_empty_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
